mor1kx_wb_commit_latte: RTL and testbench

Commit/exception controller at the consumer end of the writeback stage of the LATTE pipeline. Retires the registered WB-stage state: SR arithmetic flags, FPCSR, exceptions and l.rfe. Resolves exception priority, saves EPCR/EEAR/ESR, flushes the pipeline, and redirects fetch to the exception vector or the return address through a valid/ack handshake.

---
 rtl/mor1kx_wb_commit_latte_pkg.sv | 51 +++++
 rtl/mor1kx_wb_commit_latte_if.sv | 13 +
 rtl/mor1kx_except_prio_latte.sv | 30 +++
 rtl/mor1kx_wb_commit_latte.sv | 138 +++++++++++++
 tb/tb_mor1kx_wb_commit_latte.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mor1kx_wb_commit_latte_pkg.sv
// mor1kx_wb_commit_latte_pkg: shared vectors, SR layout, states and exception record
package mor1kx_wb_commit_latte_pkg;

    localparam int FPCSR_WIDTH = 12;
    localparam int VEC_W = 12;

    localparam logic [VEC_W-1:0] BERR_VECTOR    = 12'h200;
    localparam logic [VEC_W-1:0] DPF_VECTOR     = 12'h300;
    localparam logic [VEC_W-1:0] IPF_VECTOR     = 12'h400;
    localparam logic [VEC_W-1:0] ALIGN_VECTOR   = 12'h600;
    localparam logic [VEC_W-1:0] ILLEGAL_VECTOR = 12'h700;
    localparam logic [VEC_W-1:0] DTLB_VECTOR    = 12'h900;
    localparam logic [VEC_W-1:0] ITLB_VECTOR    = 12'hA00;
    localparam logic [VEC_W-1:0] SYSCALL_VECTOR = 12'hC00;
    localparam logic [VEC_W-1:0] TRAP_VECTOR    = 12'hE00;

    localparam int SR_F   = 0;
    localparam int SR_CY  = 1;
    localparam int SR_OV  = 2;
    localparam int SR_SM  = 3;
    localparam int SR_IEE = 4;
    localparam int SR_TEE = 5;
    localparam int SR_DSX = 6;

    localparam logic [6:0] SR_RESET = 7'b000_1000;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_REDIRECT
    } state_t;

    typedef struct packed {
        logic ibus_err;
        logic itlb_miss;
        logic ipagefault;
        logic ibus_align;
        logic illegal;
        logic syscall;
        logic trap;
        logic dbus;
        logic dtlb_miss;
        logic dpagefault;
        logic align;
    } except_t;

    function automatic logic flag_next(input logic cur, input logic set, input logic clr);
        return set ? 1'b1 : clr ? 1'b0 : cur;
    endfunction

endpackage

// File: rtl/mor1kx_wb_commit_latte_if.sv
// mor1kx_wb_commit_latte_if: flush/redirect handshake between commit and fetch
interface mor1kx_wb_commit_latte_if #(
    parameter int OW = 32
);
    logic          pipeline_flush;
    logic          redirect_valid;
    logic [OW-1:0] redirect_npc;
    logic          stall;
    logic          fetch_ack;

    modport master(output pipeline_flush, redirect_valid, redirect_npc, stall, input fetch_ack);
    modport slave(input pipeline_flush, redirect_valid, redirect_npc, stall, output fetch_ack);
endinterface

// File: rtl/mor1kx_except_prio_latte.sv
// mor1kx_except_prio_latte: fixed-priority exception select -> vector offset and class
module mor1kx_except_prio_latte
    import mor1kx_wb_commit_latte_pkg::*;
(
    input  except_t          exc,
    output logic [VEC_W-1:0] offset,
    output logic             data_exc,
    output logic             sys_exc
);
    logic fetch_side;

    // first set flag in priority order wins; data-side faults only when no earlier fault
    always_comb begin
        fetch_side = exc.ibus_err | exc.itlb_miss | exc.ipagefault | exc.ibus_align;
        offset = exc.ibus_err   ? BERR_VECTOR :
                 exc.itlb_miss  ? ITLB_VECTOR :
                 exc.ipagefault ? IPF_VECTOR :
                 exc.ibus_align ? ALIGN_VECTOR :
                 exc.illegal    ? ILLEGAL_VECTOR :
                 exc.syscall    ? SYSCALL_VECTOR :
                 exc.trap       ? TRAP_VECTOR :
                 exc.dbus       ? BERR_VECTOR :
                 exc.dtlb_miss  ? DTLB_VECTOR :
                 exc.dpagefault ? DPF_VECTOR :
                 exc.align      ? ALIGN_VECTOR : '0;
        sys_exc = ~fetch_side & ~exc.illegal & exc.syscall;
        data_exc = ~fetch_side & ~exc.illegal & ~exc.syscall & ~exc.trap &
                   (exc.dbus | exc.dtlb_miss | exc.dpagefault | exc.align);
    end
endmodule

// File: rtl/mor1kx_wb_commit_latte.sv
// mor1kx_wb_commit_latte: WB commit of SR/FPCSR, exception entry, l.rfe and fetch redirect
module mor1kx_wb_commit_latte
    import mor1kx_wb_commit_latte_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter logic [OPTION_OPERAND_WIDTH-1:0] OPTION_EXCEPT_BASE = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wb_valid_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] pc_wb_i,
    input  logic                            wb_delay_slot_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] lsu_adr_i,
    input  logic                            wb_flag_set_i,
    input  logic                            wb_flag_clear_i,
    input  logic                            wb_atomic_flag_set_i,
    input  logic                            wb_atomic_flag_clear_i,
    input  logic                            wb_carry_set_i,
    input  logic                            wb_carry_clear_i,
    input  logic                            wb_overflow_set_i,
    input  logic                            wb_overflow_clear_i,
    input  logic [FPCSR_WIDTH-1:0]          wb_fpcsr_i,
    input  logic                            wb_fpcsr_set_i,
    input  logic                            wb_except_ibus_err_i,
    input  logic                            wb_except_itlb_miss_i,
    input  logic                            wb_except_ipagefault_i,
    input  logic                            wb_except_ibus_align_i,
    input  logic                            wb_except_illegal_i,
    input  logic                            wb_except_syscall_i,
    input  logic                            wb_except_trap_i,
    input  logic                            wb_except_dbus_i,
    input  logic                            wb_except_dtlb_miss_i,
    input  logic                            wb_except_dpagefault_i,
    input  logic                            wb_except_align_i,
    input  logic                            wb_excepts_en_i,
    input  logic                            wb_op_rfe_i,
    output logic                            sr_flag_o,
    output logic                            sr_cy_o,
    output logic                            sr_ov_o,
    output logic                            sr_sm_o,
    output logic                            sr_iee_o,
    output logic                            sr_tee_o,
    output logic                            sr_dsx_o,
    output logic [FPCSR_WIDTH-1:0]          fpcsr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] epcr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] eear_o,
    output logic [6:0]                      esr_o,
    mor1kx_wb_commit_latte_if.master        fe
);
    localparam int OW = OPTION_OPERAND_WIDTH;

    state_t           state, state_nxt;
    logic [6:0]       sr, esr;
    logic [FPCSR_WIDTH-1:0] fpcsr;
    logic [OW-1:0]    epcr, eear, npc;
    except_t          exc;
    logic [VEC_W-1:0] vec_off;
    logic             data_exc, sys_exc;
    logic             run, take_exc, take_rfe;

    assign exc = {wb_except_ibus_err_i, wb_except_itlb_miss_i, wb_except_ipagefault_i,
                  wb_except_ibus_align_i, wb_except_illegal_i, wb_except_syscall_i,
                  wb_except_trap_i, wb_except_dbus_i, wb_except_dtlb_miss_i,
                  wb_except_dpagefault_i, wb_except_align_i};

    mor1kx_except_prio_latte u_prio (
        .exc      (exc),
        .offset   (vec_off),
        .data_exc (data_exc),
        .sys_exc  (sys_exc)
    );

    assign run      = state == ST_RUN;
    assign take_exc = wb_valid_i & wb_excepts_en_i & (|exc);
    assign take_rfe = wb_valid_i & wb_op_rfe_i & ~take_exc;

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_RUN;
        else
            state <= state_nxt;
    end

    // next state and handshake outputs; flush lasts one cycle, redirect holds until ack
    always_comb begin
        state_nxt = state == ST_RUN   ? ((take_exc | take_rfe) ? ST_FLUSH : ST_RUN) :
                    state == ST_FLUSH ? ST_REDIRECT :
                    fe.fetch_ack      ? ST_RUN : ST_REDIRECT;
        fe.pipeline_flush = state == ST_FLUSH;
        fe.redirect_valid = state == ST_REDIRECT;
        fe.stall = ~run;
    end

    // architectural state commit; WB strobes outside RUN are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            sr    <= SR_RESET;
            esr   <= '0;
            fpcsr <= '0;
            epcr  <= '0;
            eear  <= '0;
            npc   <= '0;
        end else if (run & take_exc) begin
            esr         <= sr;
            sr[SR_SM]   <= 1'b1;
            sr[SR_IEE]  <= 1'b0;
            sr[SR_TEE]  <= 1'b0;
            sr[SR_DSX]  <= wb_delay_slot_i;
            epcr <= wb_delay_slot_i ? pc_wb_i - OW'(4) : sys_exc ? pc_wb_i + OW'(4) : pc_wb_i;
            eear <= data_exc ? lsu_adr_i : pc_wb_i;
            npc  <= OPTION_EXCEPT_BASE + OW'(vec_off);
        end else if (run & take_rfe) begin
            sr  <= esr;
            npc <= epcr;
        end else if (run & wb_valid_i) begin
            sr[SR_F]  <= flag_next(sr[SR_F], wb_flag_set_i | wb_atomic_flag_set_i,
                                   wb_flag_clear_i | wb_atomic_flag_clear_i);
            sr[SR_CY] <= flag_next(sr[SR_CY], wb_carry_set_i, wb_carry_clear_i);
            sr[SR_OV] <= flag_next(sr[SR_OV], wb_overflow_set_i, wb_overflow_clear_i);
            if (wb_fpcsr_set_i)
                fpcsr <= wb_fpcsr_i;
        end
    end

    assign fe.redirect_npc = npc;
    assign sr_flag_o = sr[SR_F];
    assign sr_cy_o   = sr[SR_CY];
    assign sr_ov_o   = sr[SR_OV];
    assign sr_sm_o   = sr[SR_SM];
    assign sr_iee_o  = sr[SR_IEE];
    assign sr_tee_o  = sr[SR_TEE];
    assign sr_dsx_o  = sr[SR_DSX];
    assign fpcsr_o   = fpcsr;
    assign epcr_o    = epcr;
    assign eear_o    = eear;
    assign esr_o     = esr;
endmodule

// File: tb/tb_mor1kx_wb_commit_latte.sv
// tb_mor1kx_wb_commit_latte: scoreboard bench for commit, exception entry, rfe and redirect
module tb_mor1kx_wb_commit_latte;
    import mor1kx_wb_commit_latte_pkg::*;

    localparam logic [10:0] EX_ILLEGAL = 11'h040;
    localparam logic [10:0] EX_SYSCALL = 11'h020;
    localparam logic [10:0] EX_TRAP    = 11'h010;
    localparam logic [10:0] EX_DTLB    = 11'h004;

    logic clk = 1'b0;
    logic rst;
    logic wb_valid_i, wb_delay_slot_i, wb_fpcsr_set_i, wb_excepts_en_i, wb_op_rfe_i;
    logic [31:0] pc_wb_i, lsu_adr_i;
    logic [FPCSR_WIDTH-1:0] wb_fpcsr_i;
    logic [10:0] exc_v;
    logic [7:0] fl_v;
    logic wb_flag_set_i, wb_flag_clear_i, wb_atomic_flag_set_i, wb_atomic_flag_clear_i;
    logic wb_carry_set_i, wb_carry_clear_i, wb_overflow_set_i, wb_overflow_clear_i;
    logic ex_ibus_err, ex_itlb, ex_ipf, ex_ibus_align, ex_illegal, ex_syscall, ex_trap;
    logic ex_dbus, ex_dtlb, ex_dpf, ex_align;
    logic sr_flag_o, sr_cy_o, sr_ov_o, sr_sm_o, sr_iee_o, sr_tee_o, sr_dsx_o;
    logic [FPCSR_WIDTH-1:0] fpcsr_o;
    logic [31:0] epcr_o, eear_o;
    logic [6:0] esr_o;

    int checks = 0;
    int failures = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    assign {wb_overflow_clear_i, wb_overflow_set_i, wb_carry_clear_i, wb_carry_set_i,
            wb_atomic_flag_clear_i, wb_atomic_flag_set_i, wb_flag_clear_i, wb_flag_set_i} = fl_v;
    assign {ex_ibus_err, ex_itlb, ex_ipf, ex_ibus_align, ex_illegal, ex_syscall, ex_trap,
            ex_dbus, ex_dtlb, ex_dpf, ex_align} = exc_v;

    mor1kx_wb_commit_latte_if #(.OW(32)) fe ();

    mor1kx_wb_commit_latte #(
        .OPTION_OPERAND_WIDTH (32),
        .OPTION_EXCEPT_BASE   (32'h0)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .wb_valid_i             (wb_valid_i),
        .pc_wb_i                (pc_wb_i),
        .wb_delay_slot_i        (wb_delay_slot_i),
        .lsu_adr_i              (lsu_adr_i),
        .wb_flag_set_i          (wb_flag_set_i),
        .wb_flag_clear_i        (wb_flag_clear_i),
        .wb_atomic_flag_set_i   (wb_atomic_flag_set_i),
        .wb_atomic_flag_clear_i (wb_atomic_flag_clear_i),
        .wb_carry_set_i         (wb_carry_set_i),
        .wb_carry_clear_i       (wb_carry_clear_i),
        .wb_overflow_set_i      (wb_overflow_set_i),
        .wb_overflow_clear_i    (wb_overflow_clear_i),
        .wb_fpcsr_i             (wb_fpcsr_i),
        .wb_fpcsr_set_i         (wb_fpcsr_set_i),
        .wb_except_ibus_err_i   (ex_ibus_err),
        .wb_except_itlb_miss_i  (ex_itlb),
        .wb_except_ipagefault_i (ex_ipf),
        .wb_except_ibus_align_i (ex_ibus_align),
        .wb_except_illegal_i    (ex_illegal),
        .wb_except_syscall_i    (ex_syscall),
        .wb_except_trap_i       (ex_trap),
        .wb_except_dbus_i       (ex_dbus),
        .wb_except_dtlb_miss_i  (ex_dtlb),
        .wb_except_dpagefault_i (ex_dpf),
        .wb_except_align_i      (ex_align),
        .wb_excepts_en_i        (wb_excepts_en_i),
        .wb_op_rfe_i            (wb_op_rfe_i),
        .sr_flag_o              (sr_flag_o),
        .sr_cy_o                (sr_cy_o),
        .sr_ov_o                (sr_ov_o),
        .sr_sm_o                (sr_sm_o),
        .sr_iee_o               (sr_iee_o),
        .sr_tee_o               (sr_tee_o),
        .sr_dsx_o               (sr_dsx_o),
        .fpcsr_o                (fpcsr_o),
        .epcr_o                 (epcr_o),
        .eear_o                 (eear_o),
        .esr_o                  (esr_o),
        .fe                     (fe.master)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_sr(input string tag, input logic [6:0] exp);
        chk(tag, {sr_dsx_o, sr_tee_o, sr_iee_o, sr_sm_o, sr_ov_o, sr_cy_o, sr_flag_o}, exp);
    endtask

    task automatic clear_in();
        wb_valid_i = 1'b0;
        wb_delay_slot_i = 1'b0;
        wb_op_rfe_i = 1'b0;
        wb_fpcsr_set_i = 1'b0;
        exc_v = '0;
        fl_v = '0;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [10:0] ex, input logic ds,
                         input logic [31:0] lsu, input logic [7:0] fl, input logic rfe);
        @(negedge clk);
        wb_valid_i = 1'b1;
        pc_wb_i = pc;
        exc_v = ex;
        wb_delay_slot_i = ds;
        lsu_adr_i = lsu;
        fl_v = fl;
        wb_op_rfe_i = rfe;
        @(negedge clk);
        clear_in();
    endtask

    task automatic redirect(input int ack_delay, input logic inject);
        int w;
        logic [31:0] exp;
        chk("flush", fe.pipeline_flush, 1);
        chk("stall_flush", fe.stall, 1);
        if (inject) begin
            wb_valid_i = 1'b1;
            fl_v = 8'h02;
            exc_v = EX_ILLEGAL;
        end
        @(negedge clk);
        clear_in();
        chk("flush_one_cycle", fe.pipeline_flush, 0);
        w = 0;
        while (!fe.redirect_valid && w < 4) begin
            @(negedge clk);
            w++;
        end
        chk("redirect_seen", fe.redirect_valid, 1);
        exp = 32'hx;
        if (sb.size() == 0)
            chk("sb_underflow", 1, 0);
        else
            exp = sb.pop_front();
        for (int i = 0; i < ack_delay; i++) begin
            chk("valid_hold", fe.redirect_valid, 1);
            chk("npc_stable", fe.redirect_npc, exp);
            @(negedge clk);
        end
        fe.fetch_ack = 1'b1;
        chk("valid_ack", fe.redirect_valid, 1);
        chk("npc", fe.redirect_npc, exp);
        @(negedge clk);
        fe.fetch_ack = 1'b0;
        chk("valid_drop", fe.redirect_valid, 0);
        chk("stall_run", fe.stall, 0);
    endtask

    logic [10:0] pex[8] = '{11'h401, 11'h00A, 11'h300, 11'h180, 11'h003, 11'h088, 11'h001, 11'h018};
    logic [31:0] pvec[8] = '{32'h200, 32'h200, 32'hA00, 32'h400, 32'h300, 32'h600, 32'h600, 32'hE00};
    logic pdata[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        clear_in();
        pc_wb_i = '0;
        lsu_adr_i = '0;
        wb_fpcsr_i = '0;
        wb_excepts_en_i = 1'b1;
        fe.fetch_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_sr("reset_sr", 7'h08);
        chk("reset_stall", fe.stall, 0);
        chk("reset_valid", fe.redirect_valid, 0);
        chk("reset_flush", fe.pipeline_flush, 0);
        chk("reset_npc", fe.redirect_npc, 0);
        chk("reset_epcr", epcr_o, 0);
        chk("reset_esr", esr_o, 0);
        chk("reset_fpcsr", fpcsr_o, 0);

        wb_fpcsr_i = 12'h5A5;
        wb_fpcsr_set_i = 1'b1;
        issue(32'h100, '0, 0, '0, 8'b0101_0011, 0);
        chk_sr("set_wins", 7'h0F);
        chk("fpcsr_write", fpcsr_o, 12'h5A5);
        chk("no_flush", fe.pipeline_flush, 0);
        chk("no_stall", fe.stall, 0);
        issue(32'h104, '0, 0, '0, 8'b1010_0010, 0);
        chk_sr("clears", 7'h08);
        chk("fpcsr_hold", fpcsr_o, 12'h5A5);
        issue(32'h108, '0, 0, '0, 8'b0001_0100, 0);
        chk_sr("atomic_set", 7'h0B);

        sb.push_back(32'h700);
        issue(32'h1000, EX_ILLEGAL, 0, 32'h55, 8'b0010_0010, 0);
        chk("ill_epcr", epcr_o, 32'h1000);
        chk("ill_eear", eear_o, 32'h1000);
        chk("ill_esr", esr_o, 7'h0B);
        chk_sr("ill_sr_suppressed", 7'h0B);
        redirect(0, 1);
        chk_sr("ignored_in_flush", 7'h0B);
        chk("ignored_epcr", epcr_o, 32'h1000);

        sb.push_back(32'h1000);
        issue(32'h1234, '0, 0, '0, 8'h00, 1);
        chk_sr("rfe_sr", 7'h0B);
        redirect(0, 0);

        sb.push_back(32'hC00);
        issue(32'h2000, EX_SYSCALL | EX_TRAP, 0, '0, 8'h00, 0);
        chk("sys_epcr", epcr_o, 32'h2004);
        chk("sys_esr", esr_o, 7'h0B);
        redirect(0, 0);
        sb.push_back(32'hC00);
        issue(32'h2000, EX_SYSCALL, 1, '0, 8'h00, 0);
        chk("sys_ds_epcr", epcr_o, 32'h1FFC);
        chk_sr("sys_ds_sr", 7'h4B);
        redirect(0, 0);
        sb.push_back(32'h1FFC);
        issue(32'h3333, '0, 0, '0, 8'h00, 1);
        chk_sr("rfe_dsx_restored", 7'h0B);
        redirect(0, 0);

        issue(32'h2100, '0, 0, '0, 8'b0010_0000, 0);
        chk_sr("cy_clear", 7'h09);
        sb.push_back(32'h900);
        issue(32'h3000, EX_DTLB, 0, 32'hDEAD0000, 8'b0001_0000, 0);
        chk("dtlb_eear", eear_o, 32'hDEAD0000);
        chk("dtlb_epcr", epcr_o, 32'h3000);
        chk_sr("dtlb_cy_unchanged", 7'h09);
        redirect(5, 0);

        for (int i = 0; i < 8; i++) begin
            sb.push_back(pvec[i]);
            issue(32'h4000 + 32'(i * 16), pex[i], 0, 32'h8000_0000 + 32'(i), 8'h00, 0);
            chk("prio_eear", eear_o, pdata[i] ? 32'h8000_0000 + 32'(i) : 32'h4000 + 32'(i * 16));
            chk("prio_epcr", epcr_o, 32'h4000 + 32'(i * 16));
            chk("prio_esr", esr_o, 7'h09);
            redirect(i % 3, 0);
        end

        wb_excepts_en_i = 1'b0;
        issue(32'h6000, EX_ILLEGAL, 0, '0, 8'b0001_0000, 0);
        wb_excepts_en_i = 1'b1;
        chk("unqualified_no_stall", fe.stall, 0);
        chk_sr("unqualified_commit", 7'h0B);

        sb.push_back(32'h700);
        issue(32'h0, EX_ILLEGAL, 1, '0, 8'h00, 0);
        chk("wrap_down", epcr_o, 32'hFFFF_FFFC);
        redirect(0, 0);
        sb.push_back(32'hC00);
        issue(32'hFFFF_FFFC, EX_SYSCALL, 0, '0, 8'h00, 0);
        chk("wrap_up", epcr_o, 32'h0);
        redirect(1, 0);

        issue(32'h5000, EX_ILLEGAL, 0, '0, 8'h00, 0);
        chk("rst_seq_flush", fe.pipeline_flush, 1);
        @(negedge clk);
        chk("rst_seq_redirect", fe.redirect_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_valid", fe.redirect_valid, 0);
        chk("rst_mid_stall", fe.stall, 0);
        chk_sr("rst_mid_sr", 7'h08);
        chk("rst_mid_epcr", epcr_o, 0);
        @(negedge clk);
        chk("rst_no_redirect", fe.redirect_valid, 0);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
